// File: rtl/llc_update_engine_pkg.sv
// Shared LLC cache types: line states, hprot encodings, directory entry and update-op records.
package llc_update_engine_pkg;

  localparam int unsigned TagW     = 20;
  localparam int unsigned LineW    = 64;
  localparam int unsigned OwnerW   = 5;
  localparam int unsigned SharersW = 16;
  localparam int unsigned OpSetW   = 16;
  localparam int unsigned OpWayW   = 5;

  typedef enum logic [1:0] {
    LlcInvalid  = 2'd0,
    LlcValid    = 2'd1,
    LlcShared   = 2'd2,
    LlcModified = 2'd3
  } llc_state_t;

  typedef enum logic {
    HprotInstr = 1'b0,
    HprotData  = 1'b1
  } hprot_t;

  typedef struct packed {
    logic [TagW-1:0]     tag;
    llc_state_t          state;
    logic [LineW-1:0]    line;
    hprot_t              hprot;
    logic [OwnerW-1:0]   owner;
    logic [SharersW-1:0] sharers;
    logic                dirty;
  } llc_entry_t;

  // Encoding 2'd0 is deliberately left undefined and treated as a no-op.
  typedef enum logic [1:0] {
    UpdWrite = 2'd1,
    UpdRst   = 2'd2,
    UpdFlush = 2'd3
  } upd_kind_t;

  typedef struct packed {
    upd_kind_t         kind;
    logic [OpSetW-1:0] set;
    logic [OpWayW-1:0] way;
    llc_entry_t        entry;
    logic [OpWayW-1:0] evict_way;
    logic              upd_evict;
  } upd_op_t;

  function automatic llc_entry_t llc_inv_entry();
    llc_entry_t e;
    e       = '0;
    e.state = LlcInvalid;
    return e;
  endfunction

endpackage

// File: rtl/llc_update_engine_flush_mask.sv
// Per-way flush selector: a way is flushed when it holds valid data (not instruction) lines.
module llc_flush_mask
  import llc_update_engine_pkg::*;
#(
  parameter int unsigned WAYS = 16
) (
  input  llc_state_t [WAYS-1:0] i_states,
  input  hprot_t     [WAYS-1:0] i_hprots,
  output logic       [WAYS-1:0] o_mask
);

  always_comb begin
    o_mask = '0;
    for (int w = 0; w < WAYS; w++) begin
      o_mask[w] = (i_states[w] == LlcValid) && (i_hprots[w] == HprotData);
    end
  end

endmodule

// File: rtl/llc_update_engine.sv
// LLC update engine: single-entry writes, full-cache reset walk and data flush walk.
// Optional write-forwarding port enabled by defining LLC_UPDATE_FWD_EN.
module llc_update_engine
  import llc_update_engine_pkg::*;
#(
  parameter int unsigned WAYS      = 16,
  parameter int unsigned SETS      = 256,
  parameter int unsigned NUM_PORTS = WAYS,
  localparam int unsigned SetW     = (SETS > 1) ? $clog2(SETS) : 1,
  localparam int unsigned WayW     = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
`ifdef LLC_UPDATE_FWD_EN
  input  logic [SetW-1:0]        i_fwd_set,
  input  logic [WayW-1:0]        i_fwd_way,
  output logic                   o_fwd_hit,
  output llc_entry_t             o_fwd_entry,
`endif
  input  logic                   i_op_valid,
  output logic                   o_op_ready,
  input  upd_op_t                i_op,
  output logic                   o_wr_en,
  output logic                   o_wr_en_evict_way,
  output logic [SetW-1:0]        o_wr_set,
  output logic [WayW-1:0]        o_wr_way,
  output llc_entry_t             o_wr_entry,
  output logic [WayW-1:0]        o_wr_evict_way,
  output logic [NUM_PORTS-1:0]   o_wr_rst_flush,
  output logic                   o_rd_en,
  output logic [SetW-1:0]        o_rd_set,
  input  llc_state_t [WAYS-1:0]  i_rd_states,
  input  hprot_t     [WAYS-1:0]  i_rd_hprots,
  output logic                   o_done_valid,
  input  logic                   i_done_ready,
  output logic                   o_busy
);

  localparam logic [SetW-1:0] LastSet = SetW'(SETS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRstWalk,
    StFlRead,
    StFlWrite,
    StDone
  } fsm_state_t;

  fsm_state_t       r_state, w_state_next;
  logic [SetW-1:0]  r_set_cnt, w_set_cnt_next;
  upd_op_t          r_op, w_op_next;
  logic [WAYS-1:0]  w_way_mask;
  logic [NUM_PORTS-1:0] w_lane_mask;
  logic             w_unused_op;

  llc_flush_mask #(
    .WAYS (WAYS)
  ) u_flush_mask (
    .i_states (i_rd_states),
    .i_hprots (i_rd_hprots),
    .o_mask   (w_way_mask)
  );

  // Lanes beyond WAYS never carry a flush.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    if (p < WAYS) begin : g_map
      assign w_lane_mask[p] = w_way_mask[p];
    end else begin : g_pad
      assign w_lane_mask[p] = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_set_cnt <= '0;
      r_op      <= '0;
    end else begin
      r_state   <= w_state_next;
      r_set_cnt <= w_set_cnt_next;
      r_op      <= w_op_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_set_cnt_next    = r_set_cnt;
    w_op_next         = r_op;
    o_op_ready        = 1'b0;
    o_wr_en           = 1'b0;
    o_wr_en_evict_way = 1'b0;
    o_wr_set          = '0;
    o_wr_way          = '0;
    o_wr_entry        = '0;
    o_wr_evict_way    = '0;
    o_wr_rst_flush    = '0;
    o_rd_en           = 1'b0;
    o_rd_set          = '0;
    o_done_valid      = 1'b0;

    unique case (r_state)
      StIdle: begin
        o_op_ready = 1'b1;
        if (i_op_valid) begin
          case (i_op.kind)
            UpdWrite: begin
              w_op_next    = i_op;
              w_state_next = StWrite;
            end
            UpdRst: begin
              w_set_cnt_next = '0;
              w_state_next   = StRstWalk;
            end
            UpdFlush: begin
              w_set_cnt_next = '0;
              w_state_next   = StFlRead;
            end
            default: ;
          endcase
        end
      end
      StWrite: begin
        o_wr_en           = 1'b1;
        o_wr_set          = r_op.set[SetW-1:0];
        o_wr_way          = r_op.way[WayW-1:0];
        o_wr_entry        = r_op.entry;
        o_wr_en_evict_way = r_op.upd_evict;
        o_wr_evict_way    = r_op.evict_way[WayW-1:0];
        w_state_next      = StIdle;
      end
      StRstWalk: begin
        o_wr_en           = 1'b1;
        o_wr_set          = r_set_cnt;
        o_wr_entry        = llc_inv_entry();
        o_wr_rst_flush    = '1;
        o_wr_en_evict_way = 1'b1;
        w_set_cnt_next    = r_set_cnt + SetW'(1);
        if (r_set_cnt == LastSet) w_state_next = StDone;
      end
      StFlRead: begin
        o_rd_en      = 1'b1;
        o_rd_set     = r_set_cnt;
        w_state_next = StFlWrite;
      end
      StFlWrite: begin
        // Read data for this set arrives exactly now, one cycle after StFlRead.
        o_wr_en        = 1'b1;
        o_wr_set       = r_set_cnt;
        o_wr_entry     = llc_inv_entry();
        o_wr_rst_flush = w_lane_mask;
        w_set_cnt_next = r_set_cnt + SetW'(1);
        w_state_next   = (r_set_cnt == LastSet) ? StDone : StFlRead;
      end
      StDone: begin
        o_done_valid = 1'b1;
        if (i_done_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign o_busy      = (r_state != StIdle);
  assign w_unused_op = ^{r_op.kind, r_op.set, r_op.way, r_op.evict_way};

`ifdef LLC_UPDATE_FWD_EN
  logic            r_fwd_valid;
  logic [SetW-1:0] r_fwd_set;
  logic [WayW-1:0] r_fwd_way;
  llc_entry_t      r_fwd_entry;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fwd_valid <= 1'b0;
      r_fwd_set   <= '0;
      r_fwd_way   <= '0;
      r_fwd_entry <= '0;
    end else if (r_state == StWrite) begin
      r_fwd_valid <= 1'b1;
      r_fwd_set   <= r_op.set[SetW-1:0];
      r_fwd_way   <= r_op.way[WayW-1:0];
      r_fwd_entry <= r_op.entry;
    end else if ((r_state == StIdle) && i_op_valid &&
                 ((i_op.kind == UpdRst) || (i_op.kind == UpdFlush))) begin
      r_fwd_valid <= 1'b0;
    end
  end

  assign o_fwd_hit   = r_fwd_valid && (i_fwd_set == r_fwd_set) && (i_fwd_way == r_fwd_way);
  assign o_fwd_entry = r_fwd_entry;
`endif

endmodule

// File: doc/llc_update_engine.md
LLC_UPDATE_ENGINE -- requirements
Module: llc_update_engine

Interface
REQ-001 SHALL have parameter WAYS, default 16, meaning ways per set (power of 2, 2..32).
REQ-002 SHALL have parameter SETS, default 256, meaning sets walked by reset/flush (power of 2).
REQ-003 SHALL have parameter NUM_PORTS, default WAYS, meaning write-enable lanes of wr_rst_flush.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: op_valid  in  1, op_ready  out  1, op  in  upd_op_t  {kind: WRITE/RST/FLUSH, set, way, entry, evict_way, upd_evict}.
REQ-006 SHALL have ports: entry is llc_entry_t {tag, state, line, hprot, owner, sharers, dirty}.
REQ-007 SHALL have ports: wr_en  out  1, wr_en_evict_way  out  1, wr_set  out  log2(SETS), wr_way  out  log2(WAYS), wr_entry  out  llc_entry_t, wr_evict_way  out  log2(WAYS).
REQ-008 SHALL have ports: wr_rst_flush  out  NUM_PORTS  per-way invalidate mask.
REQ-009 SHALL have ports: rd_en  out  1, rd_set  out  log2(SETS), rd_states  in  WAYS x llc_state_t, rd_hprots  in  WAYS x hprot_t (valid exactly 1 cycle after rd_en).
REQ-010 SHALL have ports: done_valid  out  1, done_ready  in  1  (reset/flush completion handshake); busy  out  1.

Function
REQ-011 SHALL implement FSM states IDLE, WRITE, RST_WALK, FL_READ, FL_WRITE, DONE.
REQ-012 SHALL assert op_ready only in IDLE; an op is accepted when op_valid && op_ready.
REQ-013 SHALL, for WRITE, register op and drive wr_en=1 with wr_set/wr_way/wr_entry exactly 1 cycle after acceptance, then return to IDLE (1 op per 2 cycles).
REQ-014 SHALL drive wr_en_evict_way=upd_evict and wr_evict_way=evict_way in that same WRITE cycle.
REQ-015 SHALL, for RST, clear set counter and walk sets 0..SETS-1 one per cycle: wr_rst_flush all-ones, wr_entry.state=INVALID, dirty=0, sharers=0, wr_en_evict_way=1, wr_evict_way=0.
REQ-016 SHALL, for FLUSH, per set: FL_READ asserts rd_en/rd_set; FL_WRITE next cycle sets wr_rst_flush[w]=1 iff rd_states[w]==VALID and rd_hprots[w]==DATA, writing INVALID/clean; 2 cycles per set.
REQ-017 SHALL increment the set counter modulo SETS; the walk ends after set SETS-1 is written, then enter DONE.
REQ-018 SHALL hold done_valid=1 in DONE until done_ready; on the handshake cycle return to IDLE.
REQ-019 SHALL keep busy=1 in every state except IDLE.
REQ-020 SHALL ignore op_valid while not IDLE; ops are never dropped (held by producer).
REQ-021 SHALL drive all write/read outputs to 0 in any cycle not listed above.
REQ-022 SHALL treat an undefined op kind as a no-op: accepted, no write, stays IDLE.

Reset
REQ-023 SHALL, on rst, asynchronously enter IDLE, clear set counter and registered op; all outputs 0 except op_ready=1.
REQ-024 SHALL abandon any walk in progress on rst with no further writes; done_valid is not raised for it.

Configuration
REQ-025 SHALL, with LLC_UPDATE_FWD_EN defined, add outputs fwd_hit (1), fwd_entry (llc_entry_t) and inputs fwd_set, fwd_way; fwd_hit=1 when the last WRITE set/way matches and no RST/FLUSH has run since, fwd_entry carrying that data.
REQ-026 SHALL, without LLC_UPDATE_FWD_EN, omit these ports and the forwarding register entirely.

Structure
REQ-027 SHALL place upd_op_t, upd_kind_t, llc_entry_t and state/hprot encodings in the shared cache types package.
REQ-028 SHALL factor the per-way flush-mask logic into sub-module llc_flush_mask (combinational, parameter WAYS).

Verification
REQ-029 SHALL test: WRITE set=5 way=3 tag=0x1A -> wr_en=1 next cycle, wr_set=5, wr_way=3, wr_entry.tag=0x1A, op_ready low 1 cycle.
REQ-030 SHALL test: RST with SETS=4 -> 4 consecutive cycles wr_rst_flush=all-ones, sets 0..3, then done_valid held until done_ready.
REQ-031 SHALL test: FLUSH, set 2 ways {0 VALID/DATA, 1 VALID/INSTR, 2 INVALID/DATA} -> set-2 mask 0b001, rd_en precedes each write by 1 cycle.
REQ-032 SHALL test: rst asserted mid-FLUSH at set 1 -> outputs 0 immediately, IDLE, no done_valid.
REQ-033 SHALL test: done_ready held low 10 cycles -> done_valid stays 1, op_ready 0, no writes.
REQ-034 SHALL test (FWD_EN): WRITE set=7 way=1 then query 7/1 -> fwd_hit=1; after RST -> fwd_hit=0.
